// File: rtl/add_simd_pipe_pkg.sv
// Shared types and defaults for the pipelined SIMD adder.
// Mode encoding travels with each beat through the pipeline.
package add_simd_pipe_pkg;

  typedef enum logic {
    MODE_FULL  = 1'b0,
    MODE_SPLIT = 1'b1
  } mode_e;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 16;
  localparam bit DEF_SAT    = 1'b1;

endpackage

// File: rtl/add_simd_pipe_if.sv
// Beat-level handshake and data bus of the SIMD adder.
// The master drives operands upstream and ready_in downstream; the slave is the adder.
interface add_simd_pipe_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16
);

  logic                      valid_in;
  logic                      ready_out;
  logic                      mode_in;
  logic [LANES*LANE_W-1:0]   data_a_in;
  logic [LANES*LANE_W-1:0]   data_b_in;
  logic                      valid_out;
  logic                      ready_in;
  logic [LANES*LANE_W-1:0]   data_out;
  logic [2*LANES-1:0]        ovf_out;
  logic                      clr_ovf;

  modport master (
    output valid_in, mode_in, data_a_in, data_b_in, ready_in, clr_ovf,
    input  ready_out, valid_out, data_out, ovf_out
  );

  modport slave (
    input  valid_in, mode_in, data_a_in, data_b_in, ready_in, clr_ovf,
    output ready_out, valid_out, data_out, ovf_out
  );

endinterface

// File: rtl/add_simd_pipe_lane.sv
// Combinational one-lane signed adder: full width, or two independent half-width sub-lanes.
// Overflow is detected one bit above the (sub-)lane width; SAT selects clamp versus wrap.
module add_simd_lane
  import add_simd_pipe_pkg::*;
#(
  parameter int LANE_W = 16,
  parameter bit SAT    = 1'b1
) (
  input  mode_e             mode_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] sum_o,
  output logic [1:0]        ovf_o
);

  localparam int H = LANE_W / 2;

  logic [LANE_W:0]   full_s;
  logic [H:0]        lo_s;
  logic [H:0]        hi_s;
  logic              full_ovf_s;
  logic              lo_ovf_s;
  logic              hi_ovf_s;
  logic [LANE_W-1:0] full_res_s;
  logic [H-1:0]      lo_res_s;
  logic [H-1:0]      hi_res_s;

  // Sign-extended sums; the split halves never see each other's carry.
  always_comb begin
    full_s     = {a_i[LANE_W-1], a_i} + {b_i[LANE_W-1], b_i};
    lo_s       = {a_i[H-1], a_i[H-1:0]} + {b_i[H-1], b_i[H-1:0]};
    hi_s       = {a_i[LANE_W-1], a_i[LANE_W-1:H]} + {b_i[LANE_W-1], b_i[LANE_W-1:H]};
    full_ovf_s = full_s[LANE_W] ^ full_s[LANE_W-1];
    lo_ovf_s   = lo_s[H] ^ lo_s[H-1];
    hi_ovf_s   = hi_s[H] ^ hi_s[H-1];

    if (SAT && full_ovf_s) begin
      full_res_s = full_s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end else begin
      full_res_s = full_s[LANE_W-1:0];
    end

    if (SAT && lo_ovf_s) begin
      lo_res_s = lo_s[H] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
    end else begin
      lo_res_s = lo_s[H-1:0];
    end

    if (SAT && hi_ovf_s) begin
      hi_res_s = hi_s[H] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
    end else begin
      hi_res_s = hi_s[H-1:0];
    end
  end

  // Mode select: full lane reports only on bit 0.
  always_comb begin
    sum_o = full_res_s;
    ovf_o = {1'b0, full_ovf_s};
    case (mode_i)
      MODE_FULL: begin
        sum_o = full_res_s;
        ovf_o = {1'b0, full_ovf_s};
      end
      MODE_SPLIT: begin
        sum_o = {hi_res_s, lo_res_s};
        ovf_o = {hi_ovf_s, lo_ovf_s};
      end
      default: begin
        sum_o = full_res_s;
        ovf_o = {1'b0, full_ovf_s};
      end
    endcase
  end

endmodule

// File: rtl/add_simd_pipe.sv
// Two-stage SIMD adder: S1 captures operands and mode, S2 registers the lane sums.
// A single enable stalls both stages while a result waits for the downstream stage.
module add_simd_pipe
  import add_simd_pipe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter bit SAT    = DEF_SAT
) (
  input logic           clk,
  input logic           rst_n,
  add_simd_pipe_if.slave bus
);

  localparam int DW = LANES * LANE_W;
  localparam int OW = 2 * LANES;

  logic          en_s;
  logic          s1_valid_q, s1_valid_d;
  mode_e         s1_mode_q,  s1_mode_d;
  logic [DW-1:0] s1_a_q,     s1_a_d;
  logic [DW-1:0] s1_b_q,     s1_b_d;
  logic          valid_out_q, valid_out_d;
  logic [DW-1:0] data_out_q,  data_out_d;
  logic [OW-1:0] ovf_q,       ovf_d;
  logic [DW-1:0] lane_sum_s;
  logic [OW-1:0] lane_ovf_s;
  logic [OW-1:0] ovf_set_s;

  assign en_s          = ~valid_out_q | bus.ready_in;
  assign bus.ready_out = en_s;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.ovf_out   = ovf_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_simd_lane #(
      .LANE_W (LANE_W),
      .SAT    (SAT)
    ) u_lane (
      .mode_i (s1_mode_q),
      .a_i    (s1_a_q[LANE_W*i +: LANE_W]),
      .b_i    (s1_b_q[LANE_W*i +: LANE_W]),
      .sum_o  (lane_sum_s[LANE_W*i +: LANE_W]),
      .ovf_o  (lane_ovf_s[2*i +: 2])
    );
  end

  // S1: capture operands with the beat; hold everything while stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (en_s) begin
      s1_valid_d = bus.valid_in;
      if (bus.valid_in) begin
        s1_mode_d = mode_e'(bus.mode_in);
        s1_a_d    = bus.data_a_in;
        s1_b_d    = bus.data_b_in;
      end else begin
        s1_mode_d = s1_mode_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2: register sums; a bubble passes as valid_out=0 and leaves data untouched.
  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    if (en_s) begin
      valid_out_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = lane_sum_s;
      end else begin
        data_out_d = data_out_q;
      end
    end else begin
      valid_out_d = valid_out_q;
    end
  end

  // Sticky overflow: a fresh set survives a simultaneous clear.
  always_comb begin
    ovf_set_s = {OW{1'b0}};
    ovf_d     = ovf_q;
    if (en_s && s1_valid_q) begin
      ovf_set_s = lane_ovf_s;
    end else begin
      ovf_set_s = {OW{1'b0}};
    end
    if (bus.clr_ovf) begin
      ovf_d = ovf_set_s;
    end else begin
      ovf_d = ovf_q | ovf_set_s;
    end
  end

  // Pipeline and flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_FULL;
      s1_a_q      <= {DW{1'b0}};
      s1_b_q      <= {DW{1'b0}};
      valid_out_q <= 1'b0;
      data_out_q  <= {DW{1'b0}};
      ovf_q       <= {OW{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_add_simd_pipe.sv
// Directed bench for add_simd_pipe: vector table plus stall, reset and overflow-clear sequences.
// A second instance built with SAT=0 shares the stimulus to cover wrap arithmetic.
module tb_add_simd_pipe;

  typedef struct {
    string       name;
    logic        mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_sat;
    logic [63:0] exp_wrap;
    logic [7:0]  exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  add_simd_pipe_if #(.LANES(4), .LANE_W(16)) bus_s ();
  add_simd_pipe_if #(.LANES(4), .LANE_W(16)) bus_w ();

  assign bus_w.valid_in  = bus_s.valid_in;
  assign bus_w.mode_in   = bus_s.mode_in;
  assign bus_w.data_a_in = bus_s.data_a_in;
  assign bus_w.data_b_in = bus_s.data_b_in;
  assign bus_w.ready_in  = bus_s.ready_in;
  assign bus_w.clr_ovf   = bus_s.clr_ovf;

  add_simd_pipe #(.LANES(4), .LANE_W(16), .SAT(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  add_simd_pipe #(.LANES(4), .LANE_W(16), .SAT(1'b0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [63:0] a, input logic [63:0] b);
    bus_s.valid_in  = v;
    bus_s.mode_in   = m;
    bus_s.data_a_in = a;
    bus_s.data_b_in = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [7];
    logic [63:0] held;
    logic [15:0] idx;
    int          sent;
    int          got;
    logic        acc;
    logic        seen;

    vecs[0] = '{"full_basic",  1'b0, 64'h1234_1234_1234_1234, 64'h0101_0101_0101_0101,
                64'h1335_1335_1335_1335, 64'h1335_1335_1335_1335, 8'h00};
    vecs[1] = '{"full_pos_ovf", 1'b0, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001,
                64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_8000, 8'h01};
    vecs[2] = '{"full_neg_ovf", 1'b0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_FFFF,
                64'h0000_0000_0000_8000, 64'h0000_0000_0000_7FFF, 8'h01};
    vecs[3] = '{"split_hi_ovf", 1'b1, 64'h0000_7F01_0000_0000, 64'h0000_01FF_0000_0000,
                64'h0000_7F00_0000_0000, 64'h0000_8000_0000_0000, 8'h20};
    vecs[4] = '{"split_both_neg", 1'b1, 64'h0000_0000_8080_0000, 64'h0000_0000_8080_0000,
                64'h0000_0000_8080_0000, 64'h0000_0000_0000_0000, 8'h0C};
    vecs[5] = '{"full_no_ovf", 1'b0, 64'hFFFE_7FFF_0000_8000, 64'h0003_8000_0000_7FFF,
                64'h0001_FFFF_0000_FFFF, 64'h0001_FFFF_0000_FFFF, 8'h00};
    vecs[6] = '{"split_nocarry", 1'b1, 64'h3F40_7F80_0000_00FF, 64'h4040_0000_0000_0001,
                64'h7F7F_7F80_0000_0000, 64'h7F80_7F80_0000_0000, 8'h40};

    drive(1'b0, 1'b0, 64'h0, 64'h0);
    bus_s.ready_in = 1'b1;
    bus_s.clr_ovf  = 1'b0;
    #12;
    check("reset_valid_out", {63'h0, bus_s.valid_out}, 64'h0);
    check("reset_data_out", bus_s.data_out, 64'h0);
    check("reset_ovf_out", {56'h0, bus_s.ovf_out}, 64'h0);
    check("reset_ready_out", {63'h0, bus_s.ready_out}, 64'h1);
    rst_n = 1'b1;
    step();

    // Table: one beat per vector, sticky flags cleared before each.
    for (int i = 0; i < 7; i++) begin
      step();
      bus_s.clr_ovf = 1'b1;
      step();
      bus_s.clr_ovf = 1'b0;
      drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b);
      step();
      drive(1'b0, 1'b0, 64'h0, 64'h0);
      check({vecs[i].name, "_latency"}, {63'h0, bus_s.valid_out}, 64'h0);
      step();
      check({vecs[i].name, "_valid"}, {63'h0, bus_s.valid_out}, 64'h1);
      check({vecs[i].name, "_sat_data"}, bus_s.data_out, vecs[i].exp_sat);
      check({vecs[i].name, "_sat_ovf"}, {56'h0, bus_s.ovf_out}, {56'h0, vecs[i].exp_ovf});
      check({vecs[i].name, "_wrap_data"}, bus_w.data_out, vecs[i].exp_wrap);
      check({vecs[i].name, "_wrap_ovf"}, {56'h0, bus_w.ovf_out}, {56'h0, vecs[i].exp_ovf});
    end

    // Stream of 8 beats with downstream stall in cycles 3-5.
    step();
    step();
    @(posedge clk);
    sent = 0;
    got  = 0;
    held = 64'h0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      #1;
      idx = sent[15:0];
      drive(sent < 8, 1'b0, {idx, idx, idx, idx}, 64'h0);
      bus_s.ready_in = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        check("stall_ready_out", {63'h0, bus_s.ready_out}, 64'h0);
        if (c == 3) held = bus_s.data_out;
        else check("stall_data_held", bus_s.data_out, held);
      end
      if (c >= 6) check("stream_no_gap", {63'h0, bus_s.valid_out}, 64'h1);
      if (bus_s.valid_out && bus_s.ready_in) begin
        idx = got[15:0];
        check("stream_order", bus_s.data_out, {idx, idx, idx, idx});
        got++;
      end
      acc = bus_s.valid_in & bus_s.ready_out;
      @(posedge clk);
      if (acc) sent++;
    end
    #1;
    drive(1'b0, 1'b0, 64'h0, 64'h0);
    bus_s.ready_in = 1'b1;
    check("stream_count", 64'(got), 64'd8);

    // Reset while a result is held at the output.
    step();
    drive(1'b1, 1'b0, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001);
    bus_s.ready_in = 1'b0;
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0);
    step();
    check("pre_reset_valid", {63'h0, bus_s.valid_out}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid_out", {63'h0, bus_s.valid_out}, 64'h0);
    check("mid_reset_data_out", bus_s.data_out, 64'h0);
    check("mid_reset_ovf_out", {56'h0, bus_s.ovf_out}, 64'h0);
    check("mid_reset_ready_out", {63'h0, bus_s.ready_out}, 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_s.ready_in = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      seen = seen | bus_s.valid_out;
    end
    check("post_reset_quiet", {63'h0, seen}, 64'h0);
    drive(1'b1, 1'b0, 64'h1234_1234_1234_1234, 64'h0101_0101_0101_0101);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0);
    step();
    check("post_reset_valid", {63'h0, bus_s.valid_out}, 64'h1);
    check("post_reset_data", bus_s.data_out, 64'h1335_1335_1335_1335);

    // Clear racing a new lane1 overflow: the new set wins.
    step();
    bus_s.clr_ovf = 1'b1;
    step();
    bus_s.clr_ovf = 1'b0;
    drive(1'b1, 1'b0, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0);
    step();
    check("ovf_lane0_set", {56'h0, bus_s.ovf_out}, 64'h01);
    drive(1'b1, 1'b0, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0001_0000);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0);
    bus_s.clr_ovf = 1'b1;
    step();
    bus_s.clr_ovf = 1'b0;
    check("clr_vs_set_sat", {56'h0, bus_s.ovf_out}, 64'h04);
    check("clr_vs_set_wrap", {56'h0, bus_w.ovf_out}, 64'h04);
    drive(1'b0, 1'b0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF);
    step();
    step();
    step();
    check("bubble_no_ovf", {56'h0, bus_s.ovf_out}, 64'h04);
    check("bubble_no_valid", {63'h0, bus_s.valid_out}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
